obuffer4: RTL

- Output-side counterpart of the 4-lane systolic input skew buffer.
- Collects the skewed result stream leaving the bottom of the 4x4 MAC array: lane k is valid one cycle after lane k-1.
- De-skews and stores one 4x4 result tile, then saturates and packs each row to int8.
- Drains the tile as four 32-bit words over a valid/ready write port, each tagged with a destination address derived from the tile's ODST tag.

---
 rtl/obuffer4.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/obuffer4.sv
// obuffer4: de-skews one 4x4 tile of MAC-array lane results, packs each row to int8,
// and drains the tile as four addressed 32-bit words over a valid/ready port.
module obuffer4 #(
  parameter int AW  = 16,
  parameter bit SAT = 1'b1
) (
  input  logic            CLK,
  input  logic            RSTN,
  input  logic            CLR,
  input  logic [3:0]      ODST_i,
  input  logic [4*AW-1:0] ORES,
  input  logic [3:0]      ORES_VALID,
  output logic [31:0]     OWORD,
  output logic            OVALID,
  input  logic            OREADY,
  output logic [5:0]      OADDR,
  output logic            BUSY,
  output logic            DONE,
  output logic            OVF
);

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;

  state_t          state_reg, state_next;
  logic [1:0]      rd_reg, rd_next;
  logic [3:0]      odst_reg;
  logic            done_reg, done_next;
  logic            ovf_reg, ovf_next;
  logic            can_capture, last_hs;
  logic [3:0]      lane_full_next;
  logic [3:0]      lane_drop;
  logic [3:0][7:0] row_bytes;

  assign can_capture = !CLR && (state_reg == IDLE || state_reg == COLLECT);
  assign last_hs     = (state_reg == DRAIN) && OREADY && (rd_reg == 2'd3);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic signed [AW-1:0] MAX8 = AW'(127);
      localparam logic signed [AW-1:0] MIN8 = AW'(-128);

      logic signed [AW-1:0] sample;
      logic [7:0]           sample8;
      logic [2:0]           wc_reg, wc_next;
      logic [7:0]           mem_reg [4];
      logic                 cap;

      assign sample = ORES[(4-gi)*AW-1 -: AW];

      // Conversion happens at write time so the drain path is a plain byte mux.
      always_comb begin
        sample8 = sample[7:0];
        if (SAT) begin
          if (sample > MAX8)      sample8 = 8'h7F;
          else if (sample < MIN8) sample8 = 8'h80;
        end
      end

      assign cap           = can_capture && ORES_VALID[gi] && (wc_reg < 3'd4);
      assign lane_drop[gi] = !CLR && ORES_VALID[gi] &&
                             ((state_reg == DRAIN) || (can_capture && wc_reg == 3'd4));

      always_comb begin
        wc_next = wc_reg;
        if (CLR || last_hs) wc_next = '0;
        else if (cap)       wc_next = wc_reg + 3'd1;
      end

      assign lane_full_next[gi] = (wc_next == 3'd4);

      always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
          wc_reg <= '0;
          for (int i = 0; i < 4; i++) mem_reg[i] <= '0;
        end else begin
          wc_reg <= wc_next;
          if (cap) mem_reg[wc_reg[1:0]] <= sample8;
        end
      end

      // Lane 0 lands in the most significant byte of the packed row.
      assign row_bytes[3-gi] = mem_reg[rd_reg];
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    rd_next    = rd_reg;
    done_next  = 1'b0;
    ovf_next   = ovf_reg | (|lane_drop);
    case (state_reg)
      IDLE: begin
        if (|ORES_VALID) state_next = COLLECT;
      end
      COLLECT: begin
        if (&lane_full_next) begin
          state_next = DRAIN;
          rd_next    = 2'd0;
        end
      end
      DRAIN: begin
        if (OREADY) begin
          rd_next = rd_reg + 2'd1;
          if (rd_reg == 2'd3) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    if (CLR) begin
      state_next = IDLE;
      rd_next    = 2'd0;
      done_next  = 1'b0;
      ovf_next   = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_reg <= IDLE;
      rd_reg    <= '0;
      odst_reg  <= '0;
      done_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      rd_reg    <= rd_next;
      done_reg  <= done_next;
      ovf_reg   <= ovf_next;
      if (!CLR && state_reg == IDLE && (|ORES_VALID)) odst_reg <= ODST_i;
    end
  end

  assign OWORD  = row_bytes;
  assign OADDR  = {odst_reg, rd_reg};
  assign OVALID = (state_reg == DRAIN);
  assign BUSY   = (state_reg != IDLE);
  assign DONE   = done_reg;
  assign OVF    = ovf_reg;

endmodule
